interval_sequencer: RTL and testbench
=====================================

Name: interval_sequencer

Overview:
Scheduler that drives the BCD countdown core through a programmable list of intervals, e.g. a work/rest program such as 05:00.00 → 01:00.00 → 05:00.00. It holds a small preset table in min/sec/10 ms BCD and loads the core with each non-zero preset in turn. On every core time-out it advances to the next preset, and it optionally loops the whole program. It sits between the button commander (which writes presets and issues start/pause/abort) and the countdown core (which consumes the load values, load strobe and count enable).

Parameters:
NUM_SLOTS, 4, number of preset table entries (2..8)
IDX_W, 2, slot index width, equal to ceil(log2(NUM_SLOTS))

Ports:
clk_core  in  1  system clock, all logic on its rising edge
rst  in  1  asynchronous active-high reset
cfg_we_i  in  1  preset write strobe
cfg_idx_i  in  IDX_W  preset slot to write
cfg_min_i  in  8  BCD minutes, 00..99
cfg_sec_i  in  8  BCD seconds, 00..59
cfg_ms_10_i  in  8  BCD hundredths, 00..99
last_slot_i  in  IDX_W  last slot of the program, sampled on start
loop_i  in  1  1 = restart at slot 0 after the last slot
start_i  in  1  one-cycle start pulse
pause_i  in  1  one-cycle pause/resume toggle pulse
abort_i  in  1  one-cycle abort pulse
time_out_i  in  1  core expiry flag, level
core_min_o  out  8  BCD minutes load value to the core
core_sec_o  out  8  BCD seconds load value to the core
core_ms_10_o  out  8  BCD hundredths load value to the core
ld_o  out  1  one-cycle core load strobe
en_o  out  1  core count enable
slot_o  out  IDX_W  current slot index
slot_done_o  out  1  one-cycle pulse when a slot expires
rounds_o  out  8  completed loops, binary, saturates at 255
busy_o  out  1  high in SEL/LOAD/RUN/PAUSE
done_o  out  1  program finished, held high
cfg_err_o  out  1  one-cycle pulse when a preset write is rejected

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state IDLE; all outputs 0.
  - Table slot 0 = 05:00.00 (min 0x05); all other slots 00:00.00.
  - Latched last slot = NUM_SLOTS-1.
- Preset writes:
  - Accepted only in IDLE or DONE, and only if every BCD nibble ≤ 9 and sec tens ≤ 5. Accepted writes update the table at the next edge.
  - A write is dropped with a cfg_err_o pulse on the next cycle when the state is busy, a nibble is invalid, or cfg_idx_i ≥ NUM_SLOTS.
- States: IDLE, SEL, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - start_i → SEL with slot = 0, rounds = 0, last_slot_i latched (clamped to NUM_SLOTS-1).
- SEL:
  - If table[slot] = 00:00.00, skip it (one cycle per skipped slot) using the advance rule below.
  - Otherwise register the slot value onto core_*_o → LOAD.
- LOAD:
  - ld_o = 1 for exactly one cycle, en_o = 0 → RUN.
- RUN:
  - en_o = 1.
  - time_out_i = 1 → slot_done_o pulse and apply the advance rule.
  - pause_i → PAUSE.
- PAUSE:
  - en_o = 0; core_*_o held; pause_i → RUN.
- Advance rule:
  - If slot < last, go to slot+1 → SEL.
  - If slot = last and loop_i = 1, go to slot 0, rounds+1 (saturating at 255) → SEL.
  - If slot = last and loop_i = 0 → DONE.
- Empty program: a whole pass that skips every slot → DONE, with no ld_o and no rounds increment. This prevents an infinite loop when loop_i = 1.
- DONE:
  - done_o = 1, en_o = 0, core_*_o hold the last loaded value.
  - start_i → SEL and restarts as from IDLE.
  - abort_i → IDLE.
- abort_i in any non-IDLE state → IDLE next cycle: en_o = 0, done_o = 0, slot_o = 0; the table is kept.
- Priority within a cycle: abort_i > time_out_i > pause_i > start_i.
- time_out_i is ignored outside RUN. The core clears it on ld_o, so a stale level cannot double-advance.
- Latency:
  - start → ld_o: 2 cycles, when slot 0 is non-zero.
  - start → en_o: 3 cycles.
  - time_out → next ld_o: 2 cycles, plus one cycle per skipped slot.
- busy_o = state in {SEL, LOAD, RUN, PAUSE}.

Test Plan:
1. Reset, start_i, last_slot_i = 0 → ld_o at +2 with core = 05:00.00; en_o at +3; time_out_i → slot_done_o pulse, then DONE with done_o = 1 and en_o = 0.
2. Slots 02:00.00 / 00:00.00 / 00:30.00, last = 2, loop_i = 0 → loads 0x02/0x00/0x00, slot 1 is skipped (no ld_o), then loads 0x00/0x30/0x00; DONE after the second time-out.
3. Two non-zero slots, loop_i = 1, four time-outs → rounds_o = 2, slot_o returns to 0, done_o stays 0.
4. pause_i in RUN → en_o = 0; time_out_i pulse while paused is ignored; second pause_i → en_o = 1 with slot unchanged.
5. Write sec = 0x60, then a valid write during RUN → both dropped, with one cfg_err_o pulse each; table unchanged.
6. abort_i and time_out_i in the same cycle during RUN → IDLE, no slot_done_o; all slots zero with loop_i = 1 → DONE within NUM_SLOTS+1 cycles, no ld_o; rst asserted mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/interval_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : interval_sequencer
// Brief   : walks a BCD countdown core through a table of interval presets
// Rev     : 1.0  initial release
// ============================================================================
module interval_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk_core,
    input  logic             rst,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic [7:0]       cfg_min_i,
    input  logic [7:0]       cfg_sec_i,
    input  logic [7:0]       cfg_ms_10_i,
    input  logic [IDX_W-1:0] last_slot_i,
    input  logic             loop_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             abort_i,
    input  logic             time_out_i,
    output logic [7:0]       core_min_o,
    output logic [7:0]       core_sec_o,
    output logic [7:0]       core_ms_10_o,
    output logic             ld_o,
    output logic             en_o,
    output logic [IDX_W-1:0] slot_o,
    output logic             slot_done_o,
    output logic [7:0]       rounds_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o
);

    localparam logic [IDX_W-1:0] C_LAST_MAX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   C_SLOTS_X  = (IDX_W + 1)'(NUM_SLOTS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d, last_q, last_d;
    logic [7:0]       rounds_q, rounds_d;
    logic             loaded_q, loaded_d;
    logic [7:0]       core_min_q, core_min_d;
    logic [7:0]       core_sec_q, core_sec_d;
    logic [7:0]       core_ms_q, core_ms_d;
    logic             slot_done_d;
    logic             ld_q, en_q, slot_done_q, busy_q, done_q, cfg_err_q;

    logic [7:0] tbl_min_q [NUM_SLOTS];
    logic [7:0] tbl_sec_q [NUM_SLOTS];
    logic [7:0] tbl_ms_q  [NUM_SLOTS];

    logic w_fmt_ok, w_idx_big, w_last_big, w_cfg_wr, w_slot_empty, w_adv, w_go;

    assign w_fmt_ok = (cfg_min_i[7:4] <= 4'd9) && (cfg_min_i[3:0] <= 4'd9) &&
                      (cfg_sec_i[7:4] <= 4'd5) && (cfg_sec_i[3:0] <= 4'd9) &&
                      (cfg_ms_10_i[7:4] <= 4'd9) && (cfg_ms_10_i[3:0] <= 4'd9);
    assign w_idx_big  = {1'b0, cfg_idx_i} >= C_SLOTS_X;
    assign w_last_big = {1'b0, last_slot_i} >= C_SLOTS_X;
    assign w_cfg_wr   = cfg_we_i && w_fmt_ok && !w_idx_big &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_slot_empty = ({tbl_min_q[slot_q], tbl_sec_q[slot_q], tbl_ms_q[slot_q]} == 24'h0);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        last_d      = last_q;
        rounds_d    = rounds_q;
        loaded_d    = loaded_q;
        core_min_d  = core_min_q;
        core_sec_d  = core_sec_q;
        core_ms_d   = core_ms_q;
        slot_done_d = 1'b0;
        w_adv       = 1'b0;
        w_go        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: w_go = start_i;
            ST_SEL: begin
                if (w_slot_empty) begin
                    w_adv = 1'b1;
                end else begin
                    core_min_d = tbl_min_q[slot_q];
                    core_sec_d = tbl_sec_q[slot_q];
                    core_ms_d  = tbl_ms_q[slot_q];
                    loaded_d   = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (time_out_i) begin
                    slot_done_d = 1'b1;
                    w_adv       = 1'b1;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (w_go) begin
            state_d  = ST_SEL;
            slot_d   = '0;
            rounds_d = '0;
            loaded_d = 1'b0;
            last_d   = w_last_big ? C_LAST_MAX : last_slot_i;
        end

        // A wrap is only allowed if this pass loaded something, so an all-zero
        // table terminates instead of spinning forever in loop mode.
        if (w_adv) begin
            if (slot_q < last_q) begin
                slot_d  = slot_q + C_IDX_ONE;
                state_d = ST_SEL;
            end else if (loop_i && loaded_q) begin
                slot_d   = '0;
                loaded_d = 1'b0;
                rounds_d = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
                state_d  = ST_SEL;
            end else begin
                state_d = ST_DONE;
            end
        end

        if (abort_i) begin
            state_d     = ST_IDLE;
            slot_d      = '0;
            slot_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            last_q      <= C_LAST_MAX;
            rounds_q    <= '0;
            loaded_q    <= 1'b0;
            core_min_q  <= '0;
            core_sec_q  <= '0;
            core_ms_q   <= '0;
            ld_q        <= 1'b0;
            en_q        <= 1'b0;
            slot_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            last_q      <= last_d;
            rounds_q    <= rounds_d;
            loaded_q    <= loaded_d;
            core_min_q  <= core_min_d;
            core_sec_q  <= core_sec_d;
            core_ms_q   <= core_ms_d;
            ld_q        <= (state_d == ST_LOAD);
            en_q        <= (state_d == ST_RUN);
            slot_done_q <= slot_done_d;
            busy_q      <= (state_d == ST_SEL) || (state_d == ST_LOAD) ||
                           (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q      <= (state_d == ST_DONE);
            cfg_err_q   <= cfg_we_i && !w_cfg_wr;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_min_q[i] <= (i == 0) ? 8'h05 : 8'h00;
                tbl_sec_q[i] <= 8'h00;
                tbl_ms_q[i]  <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_cfg_wr && (cfg_idx_i == IDX_W'(i))) begin
                    tbl_min_q[i] <= cfg_min_i;
                    tbl_sec_q[i] <= cfg_sec_i;
                    tbl_ms_q[i]  <= cfg_ms_10_i;
                end
            end
        end
    end

    assign core_min_o   = core_min_q;
    assign core_sec_o   = core_sec_q;
    assign core_ms_10_o = core_ms_q;
    assign ld_o         = ld_q;
    assign en_o         = en_q;
    assign slot_o       = slot_q;
    assign slot_done_o  = slot_done_q;
    assign rounds_o     = rounds_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cfg_err_o    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_interval_sequencer
// Brief   : directed programs then random tables/programs vs a slot-walk model
// Rev     : 1.0  initial release
// ============================================================================
module tb_interval_sequencer;

    localparam int NUM_SLOTS = 4;
    localparam int IDX_W     = 2;

    logic             clk_core = 1'b0;
    logic             rst;
    logic             cfg_we_i;
    logic [IDX_W-1:0] cfg_idx_i;
    logic [7:0]       cfg_min_i, cfg_sec_i, cfg_ms_10_i;
    logic [IDX_W-1:0] last_slot_i;
    logic             loop_i, start_i, pause_i, abort_i, time_out_i;
    logic [7:0]       core_min_o, core_sec_o, core_ms_10_o;
    logic             ld_o, en_o, slot_done_o, busy_o, done_o, cfg_err_o;
    logic [IDX_W-1:0] slot_o;
    logic [7:0]       rounds_o;

    always #5 clk_core = ~clk_core;

    interval_sequencer #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_dut (
        .clk_core    (clk_core),
        .rst         (rst),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_min_i   (cfg_min_i),
        .cfg_sec_i   (cfg_sec_i),
        .cfg_ms_10_i (cfg_ms_10_i),
        .last_slot_i (last_slot_i),
        .loop_i      (loop_i),
        .start_i     (start_i),
        .pause_i     (pause_i),
        .abort_i     (abort_i),
        .time_out_i  (time_out_i),
        .core_min_o  (core_min_o),
        .core_sec_o  (core_sec_o),
        .core_ms_10_o(core_ms_10_o),
        .ld_o        (ld_o),
        .en_o        (en_o),
        .slot_o      (slot_o),
        .slot_done_o (slot_done_o),
        .rounds_o    (rounds_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_min [NUM_SLOTS];
    logic [7:0] m_sec [NUM_SLOTS];
    logic [7:0] m_ms  [NUM_SLOTS];
    int         m_rounds;
    bit         m_busy;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    function automatic bit bcd_ok(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms);
        return (mn[7:4] <= 4'd9) && (mn[3:0] <= 4'd9) && (sc[7:4] <= 4'd5) &&
               (sc[3:0] <= 4'd9) && (ms[7:4] <= 4'd9) && (ms[3:0] <= 4'd9);
    endfunction

    function automatic bit slot_empty(input int p);
        return {m_min[p], m_sec[p], m_ms[p]} == 24'h0;
    endfunction

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_core", {core_min_o, core_sec_o, core_ms_10_o}, 32'h0);
        chk_eq("rst_ctl", {ld_o, en_o, slot_o, slot_done_o, rounds_o, busy_o, done_o, cfg_err_o}, 32'h0);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_min[i] = (i == 0) ? 8'h05 : 8'h00;
            m_sec[i] = 8'h00;
            m_ms[i]  = 8'h00;
        end
        m_rounds = 0;
        m_busy   = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] mn, input logic [7:0] sc,
                             input logic [7:0] ms);
        bit ok;
        ok = !m_busy && bcd_ok(mn, sc, ms) && (idx < NUM_SLOTS);
        cfg_we_i = 1'b1; cfg_idx_i = IDX_W'(idx);
        cfg_min_i = mn; cfg_sec_i = sc; cfg_ms_10_i = ms;
        step();
        cfg_we_i = 1'b0;
        chk_eq("cfg_err", cfg_err_o, ok ? 0 : 1);
        if (ok) begin
            m_min[idx] = mn; m_sec[idx] = sc; m_ms[idx] = ms;
        end
    endtask

    // Advance rule: next slot, wrap (only if this pass loaded something), or finish.
    task automatic advance(inout int p, inout bit pl, input int last, input bit lp, output bit fin);
        fin = 1'b0;
        if (p < last) begin
            p++;
        end else if (lp && pl) begin
            p = 0;
            pl = 1'b0;
            if (m_rounds < 255) m_rounds++;
        end else begin
            fin = 1'b1;
        end
    endtask

    task automatic run_prog(input int last, input bit lp, input int n_to, input bit do_pause,
                            input bit busy_wr, input bit abort_to, input bit abort_done);
        int p, t, cur;
        bit pl, fin;
        loop_i = lp; last_slot_i = IDX_W'(last);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        m_busy = 1'b1; m_rounds = 0; p = 0; pl = 1'b0; fin = 1'b0;
        for (int n = 0; n <= n_to && !fin; n++) begin
            t = 1;
            if (n > 0) begin
                time_out_i = 1'b1;
                step();
                time_out_i = 1'b0;
                chk_eq("slot_done", slot_done_o, 1);
                advance(p, pl, last, lp, fin);
            end
            while (!fin && slot_empty(p)) begin
                t++;
                advance(p, pl, last, lp, fin);
            end
            cur = 1;
            while (!(ld_o || done_o) && cur < 40) begin
                step();
                cur++;
            end
            if (fin) begin
                chk_eq("done_lat", cur, t);
                chk_eq("done_o", done_o, 1);
                chk_eq("done_en", en_o, 0);
                chk_eq("done_busy", busy_o, 0);
                chk_eq("done_slot", slot_o, last);
                m_busy = 1'b0;
            end else begin
                pl = 1'b1;
                chk_eq("ld_lat", cur, t + 1);
                chk_eq("ld_val", {core_min_o, core_sec_o, core_ms_10_o}, {m_min[p], m_sec[p], m_ms[p]});
                chk_eq("ld_slot", slot_o, p);
                chk_eq("ld_rounds", rounds_o, m_rounds);
                chk_eq("ld_done", done_o, 0);
                step();
                chk_eq("run_ld", ld_o, 0);
                chk_eq("run_en", en_o, 1);
                if (n == 0 && do_pause) begin
                    pause_i = 1'b1; step(); pause_i = 1'b0;
                    chk_eq("pause_en", en_o, 0);
                    chk_eq("pause_busy", busy_o, 1);
                    time_out_i = 1'b1; step(); time_out_i = 1'b0;
                    chk_eq("pause_to_ign", {slot_done_o, en_o}, 0);
                    chk_eq("pause_hold", {core_min_o, core_sec_o, core_ms_10_o}, {m_min[p], m_sec[p], m_ms[p]});
                    pause_i = 1'b1; step(); pause_i = 1'b0;
                    chk_eq("resume_en", en_o, 1);
                    chk_eq("resume_slot", slot_o, p);
                end
                if (n == 0 && busy_wr)
                    cfg_write(int'($urandom_range(0, NUM_SLOTS - 1)), 8'h01, 8'h02, 8'h03);
                repeat ($urandom_range(0, 4)) step();
                chk_eq("dwell_en", en_o, 1);
            end
        end
        if (!fin) begin
            abort_i = 1'b1; time_out_i = abort_to;
            step();
            abort_i = 1'b0; time_out_i = 1'b0;
            chk_eq("abort_sd", slot_done_o, 0);
            chk_eq("abort_st", {busy_o, en_o, done_o, slot_o}, 0);
            m_busy = 1'b0;
        end else if (abort_done) begin
            abort_i = 1'b1; step(); abort_i = 1'b0;
            chk_eq("abort_done", {done_o, busy_o, slot_o}, 0);
        end
    endtask

    function automatic logic [7:0] rnd_bcd(input int max_tens);
        return {4'($urandom_range(0, max_tens)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        rst = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_min_i = '0; cfg_sec_i = '0;
        cfg_ms_10_i = '0; last_slot_i = '0; loop_i = 1'b0; start_i = 1'b0;
        pause_i = 1'b0; abort_i = 1'b0; time_out_i = 1'b0;
        do_reset();

        // Default table, single slot, one time-out to DONE.
        run_prog(0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Skipped middle slot.
        cfg_write(0, 8'h02, 8'h00, 8'h00);
        cfg_write(2, 8'h00, 8'h30, 8'h00);
        run_prog(2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Looping two-slot program, pause, busy write, rejected write.
        cfg_write(1, 8'h01, 8'h00, 8'h50);
        cfg_write(2, 8'h00, 8'h60, 8'h00);
        run_prog(1, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0);

        // Empty program in loop mode.
        for (int i = 0; i < NUM_SLOTS; i++) cfg_write(i, 8'h00, 8'h00, 8'h00);
        run_prog(NUM_SLOTS - 1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case ($urandom_range(0, 9))
                    0:       cfg_write(i, rnd_bcd(9), {4'($urandom_range(6, 15)), 4'h0}, rnd_bcd(9));
                    1:       cfg_write(i, {4'h1, 4'($urandom_range(10, 15))}, rnd_bcd(5), rnd_bcd(9));
                    2, 3, 4: cfg_write(i, 8'h00, 8'h00, 8'h00);
                    default: cfg_write(i, rnd_bcd(9), rnd_bcd(5), rnd_bcd(9));
                endcase
            end
            run_prog(int'($urandom_range(0, NUM_SLOTS - 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while running.
        cfg_write(0, 8'h00, 8'h10, 8'h00);
        loop_i = 1'b0; last_slot_i = '0;
        start_i = 1'b1; step(); start_i = 1'b0;
        repeat (3) step();
        chk_eq("pre_rst_en", en_o, 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
